alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode/issue stage sitting directly upstream of the 32-bit ALU (`alu32`) in the integer pipeline. It accepts RV32I OP, OP-IMM and LUI instructions over a valid/ready handshake and reads operands from an internal 32×32 register file. It drives the ALU's `a`/`b`/`op` from a registered execute slot and writes the combinational ALU result back to `rd` at the end of the execute cycle. Throughput is one instruction per cycle.

## Interface
Parameters:
- none (all widths fixed at 32 bits; encodings come from `alu_pkg`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  `in_instr` holds an instruction
- `in_ready`  out  1  stage accepts this cycle; transfer happens when `in_valid & in_ready`
- `in_instr`  in  32  RV32I instruction word
- `alu_a`  out  32  ALU operand A
- `alu_b`  out  32  ALU operand B (shift amount taken from `[4:0]`)
- `alu_op`  out  4  ALU opcode
- `alu_result`  in  32  combinational ALU result
- `alu_zero`  in  1  ALU zero flag
- `wb_valid`  out  1  one-cycle pulse: a retirement happened
- `wb_rd`  out  5  retired destination register
- `wb_data`  out  32  retired value
- `wb_zero`  out  1  retired zero flag
- `illegal`  out  1  one-cycle pulse: the accepted instruction was unsupported

## Operation
- **ALU opcodes:**
  - AND 0000, OR 0001, ADD 0010, XOR 0100, SUB 0110, SLT 0111, SLL 1000, SRL 1001, SRA 1010.
- **Decode, OP (0110011):**
  - funct3 000: ADD (funct7 0000000) or SUB (funct7 0100000).
  - 001 SLL, 010 SLT, 100 XOR, 110 OR, 111 AND.
  - 101: SRL (funct7 0000000) or SRA (funct7 0100000).
- **Decode, OP-IMM (0010011):**
  - funct3 000 ADDI, 010 SLTI, 100 XORI, 110 ORI, 111 ANDI.
  - 001 SLLI (funct7 0).
  - 101: SRLI (funct7 0) or SRAI (funct7 0100000).
  - Immediate is sign-extended `instr[31:20]`.
- **Decode, LUI (0110111):** `a`=0, `b`=`{instr[31:12],12'b0}`, op ADD.
- **Illegal:** everything else, including SLTU/SLTIU and bad funct7.
  - The instruction is accepted and `illegal` pulses the next cycle.
  - The execute slot stays empty and nothing is written back.
- **Execute slot:** registers `ex_valid`, `ex_rd`, `ex_a`, `ex_b`, `ex_op`.
  - Loaded on each transfer.
  - `ex_valid` clears when no transfer occurs.
- **ALU drive:** `alu_a`/`alu_b`/`alu_op` come directly from the slot.
- **Writeback:** at the clock edge ending a cycle with `ex_valid`, write `alu_result` to `ex_rd`.
- **x0 handling:**
  - Reads of x0 return 0.
  - Writes to x0 are discarded, but `wb_valid` still pulses with `wb_rd`=0.
- **Register file:** internal, cleared to 0 on reset.
- **in_ready:**
  - 0 during reset.
  - Otherwise 1, except as defined in Configuration.
  - It may depend combinationally on `in_instr`.

## Timing
- **Reset values:** all outputs 0, i.e. `in_ready`, `alu_*`, `wb_*` and `illegal`.
- **Accept to ALU:** accept in cycle N → ALU driven in cycle N+1.
- **Register update:** register file updated at the end of N+1.
- **Retirement pulse:** `wb_valid`/`wb_rd`/`wb_data`/`wb_zero` registered and visible in cycle N+2.
- **Simultaneous read/write (cycle N+1):**
  - An instruction accepted in N+1 that reads the `rd` being written that cycle must observe the new value.
  - This is the forwarding path, or a stall (see Configuration).
- **Reset mid-operation:** `rst_n` low in the execute cycle suppresses the writeback and clears `ex_valid`.

## Configuration
- **Macro `ALU_ISSUE_FORWARD_EN`:**
  - **Defined:** `alu_result` is forwarded to operand reads whose source matches `ex_rd` (≠0) while `ex_valid`. `in_ready` stays 1, so dependent back-to-back instructions issue every cycle.
  - **Undefined:** `in_ready` is 0 whenever `ex_valid`, `ex_rd`≠0 and a used source (rs1, or rs2 for OP) equals `ex_rd`. This costs one bubble, after which the instruction reads the updated register file.
  - The register file bypasses write-to-read in the same cycle in both builds.

## Structure
- **Package `alu_pkg`:**
  - ALU opcode localparams.
  - RV32I opcode/funct constants.
  - A typedef for the decoded micro-op (`rd`, `rs1`, `rs2`, `use_rs2`, `use_imm`, `imm`, `op`, `is_lui`, `illegal`).
- **Sub-module `regfile32`:**
  - 2 read ports, 1 write port.
  - x0 hardwired to 0.
  - Synchronous active-low clear.
  - Combinational reads with write bypass.
- Decode logic lives in the top as a package function.

## Test plan
- **Single ADDI:** after reset, `addi x1,x0,5` → ALU sees a=0, b=5, op 0010; cycle N+2 `wb_valid`, `wb_rd`=1, `wb_data`=5.
- **Back-to-back dependency:** `addi x1,x0,7` then immediately `add x2,x1,x1`.
  - With forwarding: no stall, `wb_data`=14.
  - Without forwarding: `in_ready` low for exactly 1 cycle, then 14.
- **Shifts and SLT:**
  - x3=0x80000000: `srai x4,x3,4` → 0xF8000000; `srli x5,x3,4` → 0x08000000.
  - x6=−1, x7=1: `slt x8,x6,x7` → 1.
- **LUI plus x0 write:** `lui x9,0x12345` → 0x12345000; `addi x0,x0,9` → `wb_rd`=0, later read of x0 returns 0.
- **Illegal:** `sltu` (funct3 011) → `illegal` pulses once, no `wb_valid`, register file unchanged.
- **Reset mid-op:** `rst_n` low during the execute cycle of `addi x10,x0,3` → no writeback, x10=0, all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes, RV32I decode constants, micro-op type and decoder
package alu_pkg;

  // ALU opcode encodings understood by alu32
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  // RV32I major opcodes handled by this stage
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // funct3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use_rs2;
    logic        use_imm;
    logic [31:0] imm;
    logic [3:0]  op;
    logic        is_lui;
    logic        illegal;
  } uop_t;

  // Anything outside the supported OP/OP-IMM/LUI subset (SLTU, SLTIU, odd funct7) is flagged illegal
  function automatic uop_t decode(input logic [31:0] instr);
    uop_t       u;
    logic [6:0] f7;
    logic [2:0] f3;
    f7        = instr[31:25];
    f3        = instr[14:12];
    u         = '0;
    u.rd      = instr[11:7];
    u.rs1     = instr[19:15];
    u.rs2     = instr[24:20];
    u.imm     = {{20{instr[31]}}, instr[31:20]};
    u.op      = ALU_ADD;
    case (instr[6:0])
      OPC_OP: begin
        u.use_rs2 = 1'b1;
        case (f3)
          F3_ADD_SUB: begin
            if (f7 == F7_BASE)     u.op = ALU_ADD;
            else if (f7 == F7_ALT) u.op = ALU_SUB;
            else                   u.illegal = 1'b1;
          end
          F3_SLL: begin u.op = ALU_SLL; u.illegal = (f7 != F7_BASE); end
          F3_SLT: begin u.op = ALU_SLT; u.illegal = (f7 != F7_BASE); end
          F3_XOR: begin u.op = ALU_XOR; u.illegal = (f7 != F7_BASE); end
          F3_OR:  begin u.op = ALU_OR;  u.illegal = (f7 != F7_BASE); end
          F3_AND: begin u.op = ALU_AND; u.illegal = (f7 != F7_BASE); end
          F3_SR: begin
            if (f7 == F7_BASE)     u.op = ALU_SRL;
            else if (f7 == F7_ALT) u.op = ALU_SRA;
            else                   u.illegal = 1'b1;
          end
          default: u.illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        u.use_imm = 1'b1;
        case (f3)
          F3_ADD_SUB: u.op = ALU_ADD;
          F3_SLT:     u.op = ALU_SLT;
          F3_XOR:     u.op = ALU_XOR;
          F3_OR:      u.op = ALU_OR;
          F3_AND:     u.op = ALU_AND;
          F3_SLL: begin u.op = ALU_SLL; u.illegal = (f7 != F7_BASE); end
          F3_SR: begin
            if (f7 == F7_BASE)     u.op = ALU_SRL;
            else if (f7 == F7_ALT) u.op = ALU_SRA;
            else                   u.illegal = 1'b1;
          end
          default: u.illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        u.use_imm = 1'b1;
        u.is_lui  = 1'b1;
        u.imm     = {instr[31:12], 12'b0};
      end
      default: u.illegal = 1'b1;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/regfile32.sv
// rtl/regfile32.sv - 32x32 register file, 2 read / 1 write, x0 hardwired, write-to-read bypass
module regfile32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);

  logic [31:0] r_mem [32];

  // Clear everything on reset; writes to x0 are dropped so entry 0 stays zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // A read of the register being written this cycle sees the incoming value
  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 :
                    (i_we && (i_waddr == i_raddr1)) ? i_wdata : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 :
                    (i_we && (i_waddr == i_raddr2)) ? i_wdata : r_mem[i_raddr2];

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I OP/OP-IMM/LUI issue stage feeding alu32; ALU_ISSUE_FORWARD_EN selects forwarding over stalling
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_zero,
  output logic        illegal
);

  uop_t        w_dec;
  logic        w_xfer;
  logic        w_stall;
  logic        w_rf_we;
  logic [31:0] w_rf_rd1;
  logic [31:0] w_rf_rd2;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_op_a;
  logic [31:0] w_op_b;

  logic        r_ex_valid;
  logic [4:0]  r_ex_rd;
  logic [31:0] r_ex_a;
  logic [31:0] r_ex_b;
  logic [3:0]  r_ex_op;
  logic        r_illegal;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_wb_zero;

  assign w_dec   = decode(in_instr);
  // Reset in the execute cycle must not commit the in-flight result
  assign w_rf_we = r_ex_valid & rst_n;

  regfile32 u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_rf_we),
    .i_waddr  (r_ex_rd),
    .i_wdata  (alu_result),
    .i_raddr1 (w_dec.rs1),
    .i_raddr2 (w_dec.rs2),
    .o_rdata1 (w_rf_rd1),
    .o_rdata2 (w_rf_rd2)
  );

`ifdef ALU_ISSUE_FORWARD_EN
  logic w_fwd1;
  logic w_fwd2;
  assign w_fwd1    = r_ex_valid && (r_ex_rd != 5'd0) && (w_dec.rs1 == r_ex_rd);
  assign w_fwd2    = r_ex_valid && (r_ex_rd != 5'd0) && (w_dec.rs2 == r_ex_rd);
  assign w_rs1_val = w_fwd1 ? alu_result : w_rf_rd1;
  assign w_rs2_val = w_fwd2 ? alu_result : w_rf_rd2;
  assign w_stall   = 1'b0;
`else
  assign w_rs1_val = w_rf_rd1;
  assign w_rs2_val = w_rf_rd2;
  // Hold a dependent instruction for one bubble until its producer has retired
  assign w_stall   = r_ex_valid && (r_ex_rd != 5'd0) && !w_dec.illegal &&
                     ((!w_dec.is_lui && (w_dec.rs1 == r_ex_rd)) ||
                      (w_dec.use_rs2 && (w_dec.rs2 == r_ex_rd)));
`endif

  assign in_ready = rst_n & ~w_stall;
  assign w_xfer   = in_valid & in_ready;
  assign w_op_a   = w_dec.is_lui  ? 32'd0     : w_rs1_val;
  assign w_op_b   = w_dec.use_imm ? w_dec.imm : w_rs2_val;

  // Execute slot: loaded by every legal transfer, empty otherwise; illegal pulses a cycle after accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_rd    <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_op    <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_ex_valid <= w_xfer & ~w_dec.illegal;
      r_illegal  <= w_xfer & w_dec.illegal;
      if (w_xfer && !w_dec.illegal) begin
        r_ex_rd <= w_dec.rd;
        r_ex_a  <= w_op_a;
        r_ex_b  <= w_op_b;
        r_ex_op <= w_dec.op;
      end
    end
  end

  // Retirement record, visible the cycle after the execute cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_zero  <= 1'b0;
    end else begin
      r_wb_valid <= r_ex_valid;
      if (r_ex_valid) begin
        r_wb_rd   <= r_ex_rd;
        r_wb_data <= alu_result;
        r_wb_zero <= alu_zero;
      end
    end
  end

  assign alu_a    = r_ex_a;
  assign alu_b    = r_ex_b;
  assign alu_op   = r_ex_op;
  assign illegal  = r_illegal;
  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign wb_zero  = r_wb_zero;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage with a behavioural alu32
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_zero;
  logic        illegal;

  int          n_checks = 0;
  int          n_errors = 0;
  int          stall_cnt;
  int          exp_stall;
  logic [31:0] rv;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_zero    (wb_zero),
    .illegal    (illegal)
  );

  // Behavioural alu32 standing in for the real ALU
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0100: alu_result = alu_a ^ alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b1000: alu_result = alu_a << alu_b[4:0];
      4'b1001: alu_result = alu_a >> alu_b[4:0];
      4'b1010: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  // Present one instruction at a falling edge, wait (bounded) for acceptance, return at the next falling edge
  task automatic send(input logic [31:0] instr);
    in_instr  = instr;
    in_valid  = 1'b1;
    stall_cnt = 0;
    #1;
    while (!in_ready && stall_cnt < 8) begin
      @(negedge clk);
      stall_cnt++;
    end
    if (!in_ready) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Read a register through addi x0,xR,0 and observe operand A in its execute cycle
  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    send(enc_i(12'd0, r, 3'b000, 5'd0));
    v = alu_a;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},   {31'b0, in_ready}, 32'd0);
    check({tag, "_alu_a"},   alu_a,             32'd0);
    check({tag, "_alu_b"},   alu_b,             32'd0);
    check({tag, "_alu_op"},  {28'b0, alu_op},   32'd0);
    check({tag, "_wbv"},     {31'b0, wb_valid}, 32'd0);
    check({tag, "_wbrd"},    {27'b0, wb_rd},    32'd0);
    check({tag, "_wbdata"},  wb_data,           32'd0);
    check({tag, "_wbzero"},  {31'b0, wb_zero},  32'd0);
    check({tag, "_illegal"}, {31'b0, illegal},  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ALU_ISSUE_FORWARD_EN
    exp_stall = 0;
`else
    exp_stall = 1;
`endif
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_instr = 32'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // addi x1,x0,5
    send(enc_i(12'd5, 5'd0, 3'b000, 5'd1));
    check("addi_a",  alu_a,           32'd0);
    check("addi_b",  alu_b,           32'd5);
    check("addi_op", {28'b0, alu_op}, 32'h2);
    @(negedge clk);
    check("addi_wbv",  {31'b0, wb_valid}, 32'd1);
    check("addi_wbrd", {27'b0, wb_rd},    32'd1);
    check("addi_wb",   wb_data,           32'd5);

    // addi x1,x0,7 then add x2,x1,x1 back to back
    send(enc_i(12'd7, 5'd0, 3'b000, 5'd1));
    send(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2));
    check("dep_stalls", stall_cnt, exp_stall);
    check("dep_a", alu_a, 32'd7);
    check("dep_b", alu_b, 32'd7);
    @(negedge clk);
    check("dep_wbrd", {27'b0, wb_rd}, 32'd2);
    check("dep_wb",   wb_data,        32'd14);

    // lui x3,0x80000; srai x4,x3,4; srli x5,x3,4
    send(enc_lui(20'h80000, 5'd3));
    send(enc_i(12'h404, 5'd3, 3'b101, 5'd4));
    check("srai_op", {28'b0, alu_op}, 32'hA);
    @(negedge clk);
    check("srai_wbrd", {27'b0, wb_rd}, 32'd4);
    check("srai_wb",   wb_data,        32'hF800_0000);
    send(enc_i(12'h004, 5'd3, 3'b101, 5'd5));
    @(negedge clk);
    check("srli_wb", wb_data, 32'h0800_0000);

    // addi x6,x0,-1; addi x7,x0,1; slt x8,x6,x7
    send(enc_i(12'hFFF, 5'd0, 3'b000, 5'd6));
    send(enc_i(12'd1, 5'd0, 3'b000, 5'd7));
    send(enc_r(7'h00, 5'd7, 5'd6, 3'b010, 5'd8));
    check("slt_a", alu_a, 32'hFFFF_FFFF);
    @(negedge clk);
    check("slt_wb", wb_data, 32'd1);

    // sub x11,x1,x1 gives zero
    send(enc_r(7'h20, 5'd1, 5'd1, 3'b000, 5'd11));
    @(negedge clk);
    check("sub_wb",   wb_data,          32'd0);
    check("sub_zero", {31'b0, wb_zero}, 32'd1);

    // lui x9,0x12345
    send(enc_lui(20'h12345, 5'd9));
    check("lui_a",  alu_a,           32'd0);
    check("lui_b",  alu_b,           32'h1234_5000);
    check("lui_op", {28'b0, alu_op}, 32'h2);
    @(negedge clk);
    check("lui_wb", wb_data, 32'h1234_5000);

    // addi x0,x0,9 retires with rd 0 but x0 stays zero
    send(enc_i(12'd9, 5'd0, 3'b000, 5'd0));
    @(negedge clk);
    check("x0_wbv",  {31'b0, wb_valid}, 32'd1);
    check("x0_wbrd", {27'b0, wb_rd},    32'd0);
    check("x0_wb",   wb_data,           32'd9);
    read_reg(5'd0, rv);
    check("x0_read", rv, 32'd0);

    // sltu x1,x2,x3 is illegal
    repeat (2) @(negedge clk);
    send(enc_r(7'h00, 5'd3, 5'd2, 3'b011, 5'd1));
    check("sltu_illegal", {31'b0, illegal},  32'd1);
    check("sltu_wbv1",    {31'b0, wb_valid}, 32'd0);
    @(negedge clk);
    check("sltu_pulse", {31'b0, illegal},  32'd0);
    check("sltu_wbv2",  {31'b0, wb_valid}, 32'd0);
    read_reg(5'd1, rv);
    check("sltu_x1", rv, 32'd7);

    // add with funct7 0100001 is illegal
    repeat (2) @(negedge clk);
    send(enc_r(7'h21, 5'd1, 5'd1, 3'b000, 5'd2));
    check("f7_illegal", {31'b0, illegal}, 32'd1);
    @(negedge clk);
    check("f7_wbv", {31'b0, wb_valid}, 32'd0);
    read_reg(5'd2, rv);
    check("f7_x2", rv, 32'd14);

    // reset during the execute cycle of addi x10,x0,3
    repeat (2) @(negedge clk);
    send(enc_i(12'd3, 5'd0, 3'b000, 5'd10));
    check("rst_pre_a", alu_b, 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst_n = 1'b1;
    read_reg(5'd10, rv);
    check("midrst_x10", rv, 32'd0);
    read_reg(5'd1, rv);
    check("midrst_x1", rv, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
